spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 23 ++
 rtl/spi_slave.sv | 167 ++++++++++++++++
 tb/tb_spi_slave.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// Pin-level SPI bus plus the host-side byte buffer handshake of the SPI slave.
interface spi_slave_if;
   logic       SCK;
   logic       MOSI;
   logic       SS_n;
   logic       MISO;
   logic       misoEn;
   logic [7:0] dataIn;
   logic       bufWrite;
   logic       bufRead;
   logic [7:0] dataOut;
   logic [7:0] statOut;

   modport slave (
      input  SCK, MOSI, SS_n, dataIn, bufWrite, bufRead,
      output MISO, misoEn, dataOut, statOut
   );

   modport master (
      output SCK, MOSI, SS_n, dataIn, bufWrite, bufRead,
      input  MISO, misoEn, dataOut, statOut
   );
endinterface

// File: rtl/spi_slave.sv
// Oversampling SPI slave: synchronizes SCK/MOSI/SS_n into clk and moves one byte
// each way per 8 SCK cycles, with a single-entry TX buffer and RX holding register.
module spi_slave #(
   parameter logic CPOL = 1'b0,
   parameter logic CPHA = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   spi_slave_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t      state_q, state_d;
   logic        sck_s1_q, sck_s2_q, sck_s3_q;
   logic        mosi_s1_q, mosi_s2_q;
   logic        ss_s1_q, ss_s2_q;
   logic [1:0]  sync_fill_q, sync_fill_d;
   logic        ss_armed_q, ss_armed_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   // Only seven bits are kept; the eighth comes straight from MOSI on byte complete.
   logic [6:0]  rx_shift_q, rx_shift_d;
   logic [7:0]  tx_buf_q, tx_buf_d;
   logic        tx_empty_q, tx_empty_d;
   logic        rx_full_q, rx_full_d;
   logic        overrun_q, overrun_d;
   logic [7:0]  data_out_q, data_out_d;
   logic        tx_load, rx_done;
   logic        sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;
   logic [7:0]  rx_byte;

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_s1_q  <= CPOL;
         sck_s2_q  <= CPOL;
         sck_s3_q  <= CPOL;
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
         ss_s1_q   <= 1'b1;
         ss_s2_q   <= 1'b1;
      end else begin
         sck_s1_q  <= bus.SCK;
         sck_s2_q  <= sck_s1_q;
         sck_s3_q  <= sck_s2_q;
         mosi_s1_q <= bus.MOSI;
         mosi_s2_q <= mosi_s1_q;
         ss_s1_q   <= bus.SS_n;
         ss_s2_q   <= ss_s1_q;
      end
   end

   assign sck_rise    = sck_s2_q & ~sck_s3_q;
   assign sck_fall    = ~sck_s2_q & sck_s3_q;
   assign lead_edge   = CPOL ? sck_fall : sck_rise;
   assign trail_edge  = CPOL ? sck_rise : sck_fall;
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge : trail_edge;
   assign rx_byte     = {rx_shift_q, mosi_s2_q};

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      tx_shift_d  = tx_shift_q;
      rx_shift_d  = rx_shift_q;
      tx_buf_d    = tx_buf_q;
      tx_empty_d  = tx_empty_q;
      rx_full_d   = rx_full_q;
      overrun_d   = overrun_q;
      data_out_d  = data_out_q;
      sync_fill_d = {sync_fill_q[0], 1'b1};
      // A falling SS_n only counts once a genuine high level has been synchronized,
      // so SS_n held low across reset cannot start a transfer.
      ss_armed_d  = ss_armed_q | (sync_fill_q[1] & ss_s2_q);
      tx_load     = 1'b0;
      rx_done     = 1'b0;

      case (state_q)
         IDLE: begin
            if (ss_armed_q && !ss_s2_q) begin
               state_d   = ACTIVE;
               bit_cnt_d = 3'd0;
               tx_load   = 1'b1;
            end
         end
         ACTIVE: begin
            if (ss_s2_q) begin
               state_d   = IDLE;
               bit_cnt_d = 3'd0;
            end else begin
               if (sample_edge) begin
                  rx_shift_d = rx_byte[6:0];
                  bit_cnt_d  = bit_cnt_q + 3'd1;
                  rx_done    = (bit_cnt_q == 3'd7);
               end
               if (shift_edge) begin
                  if (bit_cnt_q == 3'd0) begin
                     tx_load = 1'b1;
                  end else begin
                     tx_shift_d = {tx_shift_q[6:0], 1'b1};
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (tx_load) begin
         if (!tx_empty_q) begin
            tx_shift_d = tx_buf_q;
            tx_empty_d = 1'b1;
         end else begin
            tx_shift_d = 8'hFF;
         end
      end
      // A host write after the load leaves the new byte pending for the next load.
      if (bus.bufWrite) begin
         tx_buf_d   = bus.dataIn;
         tx_empty_d = 1'b0;
      end

      if (rx_done) begin
         if (!rx_full_q || bus.bufRead) begin
            data_out_d = rx_byte;
            rx_full_d  = 1'b1;
            overrun_d  = rx_full_q ? 1'b0 : overrun_q;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (bus.bufRead) begin
         rx_full_d = 1'b0;
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= 3'd0;
         tx_shift_q  <= 8'hFF;
         rx_shift_q  <= 7'd0;
         tx_buf_q    <= 8'h00;
         tx_empty_q  <= 1'b1;
         rx_full_q   <= 1'b0;
         overrun_q   <= 1'b0;
         data_out_q  <= 8'h00;
         sync_fill_q <= 2'b00;
         ss_armed_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         tx_buf_q    <= tx_buf_d;
         tx_empty_q  <= tx_empty_d;
         rx_full_q   <= rx_full_d;
         overrun_q   <= overrun_d;
         data_out_q  <= data_out_d;
         sync_fill_q <= sync_fill_d;
         ss_armed_q  <= ss_armed_d;
      end
   end

   assign bus.MISO    = tx_shift_q[7];
   assign bus.misoEn  = (state_q == ACTIVE);
   assign bus.dataOut = data_out_q;
   assign bus.statOut = {4'h0, (state_q == ACTIVE), overrun_q, tx_empty_q, rx_full_q};
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one DUT per SPI mode behind a shared master model, checked
// against a byte-level reference of the buffer/status rules.
module tb_spi_slave;
   localparam int HALF = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic       sck_act, mosi, ss_n, buf_write, buf_read;
   logic [7:0] data_in;
   logic [1:0] mode;

   logic       miso_v [4];
   logic       en_v   [4];
   logic [7:0] dout_v [4];
   logic [7:0] stat_v [4];
   logic       miso_obs;

   int tests_run = 0;
   int tests_failed = 0;
   int rx_rise_cnt = 0;
   logic rx_full_prev = 1'b0;

   logic [7:0] m_buf [4];
   logic [7:0] m_data [4];
   logic [7:0] m_next_tx [4];
   logic       m_valid [4];
   logic       m_full [4];
   logic       m_ovr [4];
   logic       m_busy [4];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 4; gi++) begin : g_mode
      localparam logic CPOL_G = (gi / 2) == 1;
      localparam logic CPHA_G = (gi % 2) == 1;
      spi_slave_if bus ();
      assign bus.SCK      = sck_act ^ CPOL_G;
      assign bus.MOSI     = mosi;
      assign bus.SS_n     = (mode == 2'(gi)) ? ss_n : 1'b1;
      assign bus.dataIn   = data_in;
      assign bus.bufWrite = (mode == 2'(gi)) & buf_write;
      assign bus.bufRead  = (mode == 2'(gi)) & buf_read;
      spi_slave #(.CPOL(CPOL_G), .CPHA(CPHA_G)) dut (.clk(clk), .reset(reset), .bus(bus));
      assign miso_v[gi] = bus.MISO;
      assign en_v[gi]   = bus.misoEn;
      assign dout_v[gi] = bus.dataOut;
      assign stat_v[gi] = bus.statOut;
   end

   assign miso_obs = miso_v[mode];

   always @(negedge clk) begin
      rx_full_prev <= stat_v[0][0];
      if (stat_v[0][0] && !rx_full_prev) rx_rise_cnt <= rx_rise_cnt + 1;
   end

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int m = 0; m < 4; m++) begin
         m_buf[m] = 8'h00; m_data[m] = 8'h00; m_next_tx[m] = 8'hFF;
         m_valid[m] = 1'b0; m_full[m] = 1'b0; m_ovr[m] = 1'b0; m_busy[m] = 1'b0;
      end
   endtask

   function automatic logic [7:0] m_take(input int m);
      logic [7:0] r;
      r = m_valid[m] ? m_buf[m] : 8'hFF;
      m_valid[m] = 1'b0;
      return r;
   endfunction

   function automatic logic [7:0] m_stat(input int m);
      return {4'h0, m_busy[m], m_ovr[m], ~m_valid[m], m_full[m]};
   endfunction

   // ---------------- master stimulus ----------------
   task automatic drive_bits(input logic [7:0] mo, input int nbits, input bit rd_last,
                             output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         if (mode[0] == 1'b0) begin
            mosi = mo[7-i];
            repeat (HALF) @(negedge clk);
            sck_act = 1'b1;
            mi = {mi[6:0], miso_obs};
            if (rd_last && i == nbits - 1) begin
               repeat (2) @(negedge clk);
               buf_read = 1'b1;
               @(negedge clk);
               buf_read = 1'b0;
               repeat (HALF - 3) @(negedge clk);
            end else begin
               repeat (HALF) @(negedge clk);
            end
            sck_act = 1'b0;
         end else begin
            sck_act = 1'b1;
            mosi = mo[7-i];
            repeat (HALF) @(negedge clk);
            sck_act = 1'b0;
            mi = {mi[6:0], miso_obs};
            repeat (HALF) @(negedge clk);
         end
      end
      repeat (HALF) @(negedge clk);
   endtask

   task automatic xfer(input logic [7:0] mo, input bit rd_last,
                       output logic [7:0] mi, output logic [7:0] exp_mi);
      if (mode[0]) exp_mi = m_take(mode);
      else exp_mi = m_next_tx[mode];
      drive_bits(mo, 8, rd_last, mi);
      if (!m_full[mode]) begin
         m_data[mode] = mo; m_full[mode] = 1'b1;
      end else if (rd_last) begin
         m_data[mode] = mo; m_ovr[mode] = 1'b0;
      end else begin
         m_ovr[mode] = 1'b1;
      end
      if (!mode[0]) m_next_tx[mode] = m_take(mode);
      $display("[TB] mode %0d byte: mosi %h miso %h expect %h", mode, mo, mi, exp_mi);
   endtask

   task automatic ss_assert();
      @(negedge clk);
      ss_n = 1'b0;
      repeat (8) @(negedge clk);
      m_busy[mode] = 1'b1;
      m_next_tx[mode] = m_take(mode);
   endtask

   task automatic ss_release();
      ss_n = 1'b1;
      repeat (8) @(negedge clk);
      m_busy[mode] = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] b);
      @(negedge clk);
      data_in = b; buf_write = 1'b1;
      @(negedge clk);
      buf_write = 1'b0;
      m_buf[mode] = b; m_valid[mode] = 1'b1;
   endtask

   task automatic do_read();
      @(negedge clk);
      buf_read = 1'b1;
      @(negedge clk);
      buf_read = 1'b0;
      m_full[mode] = 1'b0; m_ovr[mode] = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int m = 0; m < 4; m++) begin
         tests_run++; if (dout_v[m] !== 8'h00) begin tests_failed++; $display("FAIL reset_dout m%0d: got %h want 00", m, dout_v[m]); end
         tests_run++; if (stat_v[m] !== 8'h02) begin tests_failed++; $display("FAIL reset_stat m%0d: got %h want 02", m, stat_v[m]); end
         tests_run++; if (miso_v[m] !== 1'b1) begin tests_failed++; $display("FAIL reset_miso m%0d: got %b want 1", m, miso_v[m]); end
         tests_run++; if (en_v[m] !== 1'b0) begin tests_failed++; $display("FAIL reset_misoen m%0d: got %b want 0", m, en_v[m]); end
      end
   endtask

   task automatic test_mode0_basic();
      logic [7:0] mi, ex;
      mode = 2'd0;
      do_write(8'hA5);
      ss_assert();
      tests_run++; if (en_v[0] !== 1'b1) begin tests_failed++; $display("FAIL basic_misoen: got %b want 1", en_v[0]); end
      tests_run++; if (stat_v[0] !== m_stat(0)) begin tests_failed++; $display("FAIL basic_stat_start: got %h want %h", stat_v[0], m_stat(0)); end
      xfer(8'h3C, 1'b0, mi, ex);
      tests_run++; if (mi !== ex) begin tests_failed++; $display("FAIL basic_miso: got %h want %h", mi, ex); end
      tests_run++; if (dout_v[0] !== 8'h3C) begin tests_failed++; $display("FAIL basic_dout: got %h want 3c", dout_v[0]); end
      tests_run++; if (stat_v[0] !== m_stat(0)) begin tests_failed++; $display("FAIL basic_stat_active: got %h want %h", stat_v[0], m_stat(0)); end
      ss_release();
      tests_run++; if (stat_v[0] !== m_stat(0)) begin tests_failed++; $display("FAIL basic_stat_idle: got %h want %h", stat_v[0], m_stat(0)); end
      tests_run++; if (en_v[0] !== 1'b0) begin tests_failed++; $display("FAIL basic_misoen_idle: got %b want 0", en_v[0]); end
   endtask

   task automatic test_overrun();
      logic [7:0] mi, ex;
      mode = 2'd0;
      do_read();
      ss_assert();
      xfer(8'h11, 1'b0, mi, ex);
      xfer(8'h22, 1'b0, mi, ex);
      tests_run++; if (dout_v[0] !== m_data[0]) begin tests_failed++; $display("FAIL ovr_dout: got %h want %h", dout_v[0], m_data[0]); end
      tests_run++; if (stat_v[0] !== m_stat(0)) begin tests_failed++; $display("FAIL ovr_stat: got %h want %h", stat_v[0], m_stat(0)); end
      ss_release();
      do_read();
      @(negedge clk);
      tests_run++; if (stat_v[0] !== m_stat(0)) begin tests_failed++; $display("FAIL ovr_cleared: got %h want %h", stat_v[0], m_stat(0)); end
   endtask

   task automatic test_empty_tx();
      logic [7:0] mi, ex;
      mode = 2'd0;
      ss_assert();
      xfer(8'($urandom), 1'b0, mi, ex);
      tests_run++; if (mi !== 8'hFF) begin tests_failed++; $display("FAIL empty_tx_miso: got %h want ff", mi); end
      ss_release();
      do_read();
   endtask

   task automatic test_modes();
      logic [7:0] mi, ex;
      for (int m = 1; m < 4; m++) begin
         mode = 2'(m);
         if (!mode[0]) do_write(8'h5A);
         ss_assert();
         if (mode[0]) do_write(8'h5A);
         xfer(8'hC3, 1'b0, mi, ex);
         tests_run++; if (mi !== 8'h5A) begin tests_failed++; $display("FAIL mode%0d_miso: got %h want 5a", m, mi); end
         tests_run++; if (dout_v[m] !== 8'hC3) begin tests_failed++; $display("FAIL mode%0d_dout: got %h want c3", m, dout_v[m]); end
         ss_release();
         tests_run++; if (stat_v[m] !== m_stat(m)) begin tests_failed++; $display("FAIL mode%0d_stat: got %h want %h", m, stat_v[m], m_stat(m)); end
         do_read();
      end
   endtask

   task automatic test_abort();
      logic [7:0] mi, ex;
      int rise0;
      mode = 2'd0;
      do_read();
      repeat (2) @(negedge clk);
      rise0 = rx_rise_cnt;
      ss_assert();
      drive_bits(8'($urandom), 4, 1'b0, mi);
      ss_release();
      tests_run++; if (stat_v[0] !== m_stat(0)) begin tests_failed++; $display("FAIL abort_partial_stat: got %h want %h", stat_v[0], m_stat(0)); end
      ss_assert();
      xfer(8'h81, 1'b0, mi, ex);
      ss_release();
      tests_run++; if (dout_v[0] !== 8'h81) begin tests_failed++; $display("FAIL abort_dout: got %h want 81", dout_v[0]); end
      tests_run++; if (rx_rise_cnt - rise0 !== 1) begin tests_failed++; $display("FAIL abort_rxfull_pulses: got %0d want 1", rx_rise_cnt - rise0); end
      do_read();
   endtask

   task automatic test_read_coincident();
      logic [7:0] mi, ex, b2;
      mode = 2'd0;
      b2 = 8'($urandom);
      do_read();
      ss_assert();
      xfer(8'($urandom), 1'b0, mi, ex);
      xfer(b2, 1'b1, mi, ex);
      tests_run++; if (dout_v[0] !== b2) begin tests_failed++; $display("FAIL coinc_dout: got %h want %h", dout_v[0], b2); end
      tests_run++; if (stat_v[0] !== m_stat(0)) begin tests_failed++; $display("FAIL coinc_stat: got %h want %h", stat_v[0], m_stat(0)); end
      ss_release();
      do_read();
   endtask

   task automatic test_reset_mid();
      logic [7:0] mi, ex, b;
      mode = 2'd0;
      do_write(8'h3E);
      ss_assert();
      xfer(8'h77, 1'b0, mi, ex);
      drive_bits(8'hF0, 4, 1'b0, mi);
      pulse_reset();
      tests_run++; if (dout_v[0] !== 8'h00) begin tests_failed++; $display("FAIL rst_mid_dout: got %h want 00", dout_v[0]); end
      tests_run++; if (stat_v[0] !== 8'h02) begin tests_failed++; $display("FAIL rst_mid_stat: got %h want 02", stat_v[0]); end
      tests_run++; if (miso_v[0] !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_miso: got %b want 1", miso_v[0]); end
      tests_run++; if (en_v[0] !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_misoen: got %b want 0", en_v[0]); end
      drive_bits(8'h96, 8, 1'b0, mi);
      tests_run++; if (stat_v[0] !== m_stat(0)) begin tests_failed++; $display("FAIL rst_mid_stay_idle: got %h want %h", stat_v[0], m_stat(0)); end
      ss_release();
      b = 8'($urandom);
      ss_assert();
      xfer(b, 1'b0, mi, ex);
      ss_release();
      tests_run++; if (dout_v[0] !== b) begin tests_failed++; $display("FAIL rst_mid_recover: got %h want %h", dout_v[0], b); end
      do_read();
   endtask

   task automatic test_random();
      logic [7:0] tx, rx, mi, ex;
      bit wr;
      for (int n = 0; n < 16; n++) begin
         mode = 2'($urandom_range(0, 3));
         tx = 8'($urandom);
         rx = 8'($urandom);
         wr = 1'($urandom_range(0, 1));
         do_read();
         if (wr && !mode[0]) do_write(tx);
         ss_assert();
         if (wr && mode[0]) do_write(tx);
         xfer(rx, 1'b0, mi, ex);
         tests_run++; if (mi !== ex) begin tests_failed++; $display("FAIL rand%0d_miso: got %h want %h", n, mi, ex); end
         tests_run++; if (dout_v[mode] !== m_data[mode]) begin tests_failed++; $display("FAIL rand%0d_dout: got %h want %h", n, dout_v[mode], m_data[mode]); end
         ss_release();
         tests_run++; if (stat_v[mode] !== m_stat(mode)) begin tests_failed++; $display("FAIL rand%0d_stat: got %h want %h", n, stat_v[mode], m_stat(mode)); end
      end
   endtask

   initial begin
      reset = 1'b1; sck_act = 1'b0; mosi = 1'b0; ss_n = 1'b1;
      buf_write = 1'b0; buf_read = 1'b0; data_in = 8'h00; mode = 2'd0;
      model_reset();
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      test_reset();
      test_mode0_basic();
      test_overrun();
      test_empty_tx();
      test_modes();
      test_abort();
      test_read_coincident();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
